// File: rtl/rp_8bit_timer.sv
// rp_8bit_timer: 8-bit prescaled timer/counter on the rp_8bit I/O bus with overflow/compare IRQs.
// Optional PWM output is built only when RP_8BIT_TIMER_PWM_EN is defined; otherwise pwm is tied low.
module rp_8bit_timer #(
    parameter logic [5:0]  BASE = 6'h10,
    parameter int unsigned CW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          io_wen,
    input  logic          io_ren,
    input  logic [5:0]    io_adr,
    input  logic [7:0]    io_wdt,
    input  logic [7:0]    io_msk,
    output logic [7:0]    io_rdt,
    output logic [1:0]    irq_req,
    input  logic [1:0]    irq_ack,
    output logic          pwm
);
    localparam logic [1:0] A_CTRL  = 2'd0;
    localparam logic [1:0] A_CNT   = 2'd1;
    localparam logic [1:0] A_CMP   = 2'd2;
    localparam logic [1:0] A_FLAGS = 2'd3;

    logic [6:0]    ctrl_q, ctrl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cmp_q, cmp_d;
    logic [1:0]    flags_q, flags_d;
    logic [9:0]    presc_q, presc_d;
    logic [7:0]    rdt_q, rdt_d;

    logic          en, ctc, ps_valid, tick, cmp_hit;
    logic [2:0]    ps;
    logic [1:0]    ie, flag_set, flag_clr;
    logic [9:0]    div_m1;
    logic [5:0]    off;
    logic          hit, wr_ctrl, wr_cnt, wr_cmp, wr_flags;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    rd_val;

    assign en  = ctrl_q[0];
    assign ps  = ctrl_q[3:1];
    assign ctc = ctrl_q[4];
    assign ie  = ctrl_q[6:5];

    // Offset arithmetic lets BASE sit at any address, not just 4-aligned ones.
    assign off      = io_adr - BASE;
    assign hit      = (off[5:2] == 4'd0);
    assign wr_ctrl  = io_wen & hit & (off[1:0] == A_CTRL);
    assign wr_cnt   = io_wen & hit & (off[1:0] == A_CNT);
    assign wr_cmp   = io_wen & hit & (off[1:0] == A_CMP);
    assign wr_flags = io_wen & hit & (off[1:0] == A_FLAGS);

    always_comb begin
        ps_valid = 1'b1;
        case (ps)
            3'd0:    div_m1 = 10'd0;
            3'd1:    div_m1 = 10'd7;
            3'd2:    div_m1 = 10'd63;
            3'd3:    div_m1 = 10'd255;
            3'd4:    div_m1 = 10'd1023;
            default: begin
                div_m1   = 10'd0;
                ps_valid = 1'b0;
            end
        endcase
    end

    assign tick    = en & ps_valid & (presc_q == div_m1);
    assign cmp_hit = (cnt_q == cmp_q);
    assign cnt_inc = (ctc && cmp_hit) ? '0 : cnt_q + CW'(1);
    assign irq_req = flags_q & ie;

    always_comb begin
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q;
        cmp_d    = cmp_q;
        flag_set = 2'b00;
        flag_clr = irq_ack;
        presc_d  = (wr_ctrl || !en || !ps_valid || tick) ? 10'd0 : presc_q + 10'd1;

        // A CNT write in the same cycle as a tick suppresses the whole tick event.
        if (tick && !wr_cnt) begin
            cnt_d       = cnt_inc;
            flag_set[1] = cmp_hit;
            flag_set[0] = (cnt_q == '1) && (cnt_inc == '0);
        end
        if (wr_ctrl)  ctrl_d = (ctrl_q & ~io_msk[6:0]) | (io_wdt[6:0] & io_msk[6:0]);
        if (wr_cnt)   cnt_d  = (cnt_q & ~io_msk) | (io_wdt & io_msk);
        if (wr_cmp)   cmp_d  = (cmp_q & ~io_msk) | (io_wdt & io_msk);
        if (wr_flags) flag_clr = flag_clr | (io_wdt[1:0] & io_msk[1:0]);

        // Set beats clear when both land on the same edge.
        flags_d = (flags_q & ~flag_clr) | flag_set;

        case (off[1:0])
            A_CTRL:  rd_val = {1'b0, ctrl_q};
            A_CNT:   rd_val = cnt_q;
            A_CMP:   rd_val = cmp_q;
            default: rd_val = {6'd0, flags_q};
        endcase
        rdt_d = (io_ren && hit) ? rd_val : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= '0;
            cnt_q   <= '0;
            cmp_q   <= '1;
            flags_q <= '0;
            presc_q <= '0;
            rdt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            flags_q <= flags_d;
            presc_q <= presc_d;
            rdt_q   <= rdt_d;
        end
    end

    assign io_rdt = rdt_q;

`ifdef RP_8BIT_TIMER_PWM_EN
    logic pwm_q;

    always_ff @(posedge clk) begin
        if (rst) pwm_q <= 1'b0;
        else     pwm_q <= en & (cnt_q < cmp_q);
    end

    assign pwm = pwm_q;
`else
    assign pwm = 1'b0;
`endif

endmodule

// File: tb/tb_rp_8bit_timer.sv
// Scoreboard bench for rp_8bit_timer: driver runs a behavioural model and queues the expected
// post-edge {io_rdt, irq_req, pwm}; a monitor pops and compares after every clock edge.
module tb_rp_8bit_timer;
    localparam logic [5:0] BASE = 6'h10;
    localparam int         W    = 11;
`ifdef RP_8BIT_TIMER_PWM_EN
    localparam bit PWM_ON = 1'b1;
`else
    localparam bit PWM_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       io_wen = 1'b0;
    logic       io_ren = 1'b0;
    logic [5:0] io_adr = '0;
    logic [7:0] io_wdt = '0;
    logic [7:0] io_msk = '0;
    logic [7:0] io_rdt;
    logic [1:0] irq_req;
    logic [1:0] irq_ack = '0;
    logic       pwm;

    rp_8bit_timer #(.BASE(BASE), .CW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_wen  (io_wen),
        .io_ren  (io_ren),
        .io_adr  (io_adr),
        .io_wdt  (io_wdt),
        .io_msk  (io_msk),
        .io_rdt  (io_rdt),
        .irq_req (irq_req),
        .irq_ack (irq_ack),
        .pwm     (pwm)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int m_ctrl, m_cnt, m_cmp, m_flags, m_phase;
    int divs[5] = '{1, 8, 64, 256, 1024};
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    bit pwm_win = 1'b0;
    int pwm_hi  = 0;

    task automatic model_reset();
        m_ctrl = 0; m_cnt = 0; m_cmp = 255; m_flags = 0; m_phase = 0;
    endtask

    // Drive one cycle of bus activity and queue what the DUT must show after the next edge.
    task automatic drive(input bit r, input bit we, input bit re, input int adr,
                         input int wdt, input int msk, input int ack);
        int off, rd, exp_rdt, exp_pwm, en, ps, ctc, nxt, set, clr, ie;
        bit hit, running, tick, wr;
        @(negedge clk);
        rst = r; io_wen = we; io_ren = re; io_adr = adr[5:0];
        io_wdt = wdt[7:0]; io_msk = msk[7:0]; irq_ack = ack[1:0];
        if (r) begin
            model_reset();
            exp_q.push_back('0);
            return;
        end
        hit = (adr >= BASE) && (adr < BASE + 4);
        off = adr - BASE;
        case (off)
            0: rd = m_ctrl;
            1: rd = m_cnt;
            2: rd = m_cmp;
            default: rd = m_flags;
        endcase
        exp_rdt = (re && hit) ? rd : 0;
        en  = m_ctrl & 1;
        ps  = (m_ctrl >> 1) & 7;
        ctc = (m_ctrl >> 4) & 1;
        exp_pwm = (PWM_ON && en == 1 && m_cnt < m_cmp) ? 1 : 0;
        running = (en == 1) && (ps < 5);
        tick = running && (m_phase == divs[ps] - 1);
        wr  = we && hit;
        set = 0;
        clr = ack & 3;
        nxt = m_cnt;
        if (tick && !(wr && off == 1)) begin
            if (m_cnt == m_cmp) set = set | 2;
            nxt = (ctc == 1 && m_cnt == m_cmp) ? 0 : (m_cnt + 1) % 256;
            if (m_cnt == 255 && nxt == 0) set = set | 1;
        end
        m_phase = (running && !tick) ? m_phase + 1 : 0;
        if (wr) begin
            case (off)
                0: begin
                    m_ctrl  = ((m_ctrl & ~msk) | (wdt & msk)) & 8'h7f;
                    m_phase = 0;
                end
                1: nxt   = ((m_cnt & ~msk) | (wdt & msk)) & 8'hff;
                2: m_cmp = ((m_cmp & ~msk) | (wdt & msk)) & 8'hff;
                default: clr = clr | (wdt & msk & 3);
            endcase
        end
        m_cnt   = nxt;
        m_flags = ((m_flags & ~clr) | set) & 3;
        ie = (m_ctrl >> 5) & 3;
        exp_q.push_back({exp_rdt[7:0], 2'(m_flags & ie), exp_pwm[0]});
    endtask

    task automatic wr(input int off, input int data);
        drive(1'b0, 1'b1, 1'b0, BASE + off, data, 8'hff, 0);
    endtask

    task automatic wrm(input int off, input int data, input int msk);
        drive(1'b0, 1'b1, 1'b0, BASE + off, data, msk, 0);
    endtask

    task automatic rd(input int off);
        drive(1'b0, 1'b0, 1'b1, BASE + off, 0, 0, 0);
    endtask

    task automatic rd_n(input int off, input int n);
        for (int i = 0; i < n; i++) rd(off);
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (pwm_win && pwm) pwm_hi++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("io_rdt",  int'(io_rdt),  int'(e[10:3]));
                check("irq_req", int'(irq_req), int'(e[2:1]));
                check("pwm",     int'(pwm),     int'(e[0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r, off, wdt, msk, ack;
        model_reset();
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);

        // reset values and unmapped read
        rd(2); rd(1); rd(0); rd(3);
        drive(1'b0, 1'b0, 1'b1, 6'h3f, 0, 0, 0);
        drive(1'b0, 1'b0, 1'b1, BASE - 1, 0, 0, 0);

        // free-running overflow with ack
        wr(1, 8'hfd); wr(0, 8'h21);
        rd_n(1, 4);
        drive(1'b0, 1'b0, 1'b1, BASE + 3, 0, 0, 1);
        rd_n(3, 2);
        wr(0, 8'h00);

        // CTC with /8 prescaler
        wr(3, 8'h03); wr(1, 8'h00); wr(2, 8'h03); wr(0, 8'h53);
        rd_n(1, 40);
        wr(0, 8'h00);

        // masked write and W1C
        wrm(0, 8'hff, 8'h01); rd(0); wr(0, 8'h00);
        wr(2, 8'hff); wr(1, 8'hfe); wr(0, 8'h01); rd(1); rd(1);
        wr(0, 8'h00); rd(3);
        wr(3, 8'h02); rd(3);

        // CNT write colliding with a tick at FF
        wr(3, 8'h03); wr(1, 8'hfe); wr(0, 8'h61); rd(1);
        wr(1, 8'h80); wr(0, 8'h00); rd(1); rd(3);

        // W1C colliding with FF->00 tick
        wr(3, 8'h03); wr(1, 8'hfe); wr(0, 8'h61); rd(1);
        wr(3, 8'h01); wr(0, 8'h00); rd(3);

        // reset mid-count
        wr(0, 8'h21); rd_n(1, 5);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        rd(0); rd(1); rd(2); rd(3);

        // PWM duty window
        wr(2, 8'h40); wr(1, 8'h00); wr(0, 8'h01); rd_n(1, 3);
        pwm_win = 1'b1;
        rd_n(1, 256);
        pwm_win = 1'b0;
        check("pwm_duty", pwm_hi, PWM_ON ? 64 : 0);
        wr(0, 8'h00);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r   = $urandom_range(0, 199);
            ack = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : 0;
            off = $urandom_range(0, 3);
            if (r == 0) begin
                drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
            end else if (r < 100) begin
                off = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : BASE + off;
                drive(1'b0, 1'b0, 1'b1, off, 0, 0, ack);
            end else if (r < 150) begin
                wdt = $urandom_range(0, 255);
                msk = ($urandom_range(0, 1) == 0) ? 8'hff : $urandom_range(0, 255);
                if (off == 0 && $urandom_range(0, 9) < 7)
                    wdt = (wdt & 8'hf1) | ($urandom_range(0, 1) << 1);
                drive(1'b0, 1'b1, 1'b0, BASE + off, wdt, msk, ack);
            end else begin
                drive(1'b0, 1'b0, 1'b0, BASE, 0, 0, ack);
            end
        end

        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        check("queue_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
